// File: rtl/rvecc_pipe.sv
// rvecc_pipe: two-stage SECDED check/correct pipeline with valid/ready flow control,
// saturating error counters and a first-error log. Define RV_ECC_PIPE_INJECT_EN to add
// the inject_flip fault-injection input applied at S1 capture.
module rvecc_pipe #(
   parameter  int DW    = 32,
   parameter  int AW    = 32,
   parameter  int CNT_W = 16,
   localparam int P     = $clog2(DW + 1 + $clog2(DW + 1)),
   localparam int EW    = P + 1
) (
   input  logic             clk,
   input  logic             rst_l,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DW-1:0]    in_data,
   input  logic [EW-1:0]    in_ecc,
   input  logic [AW-1:0]    in_addr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DW-1:0]    out_data,
   output logic [EW-1:0]    out_ecc,
   output logic [AW-1:0]    out_addr,
   output logic             out_single_err,
   output logic             out_double_err,
   input  logic             cnt_clear,
   output logic [CNT_W-1:0] single_cnt,
   output logic [CNT_W-1:0] double_cnt,
   input  logic             log_clear,
   output logic             log_valid,
   output logic             log_double,
   output logic [AW-1:0]    log_addr,
   output logic [EW-1:0]    log_syndrome
`ifdef RV_ECC_PIPE_INJECT_EN
  ,input  logic [DW+EW-1:0] inject_flip
`endif
);

   localparam int NPOS = DW + P;

   // Check bits sit at power-of-two positions, data fills the rest in ascending order.
   function automatic logic [NPOS:1] f_to_cw(input logic [DW-1:0] d, input logic [EW-2:0] c);
      logic [NPOS:1] cw;
      int j;
      int k;
      cw = '0;
      j  = 0;
      k  = 0;
      for (int pos = 1; pos <= NPOS; pos++) begin
         if ((pos & (pos - 1)) == 0) begin
            cw[pos] = c[k];
            k++;
         end else begin
            cw[pos] = d[j];
            j++;
         end
      end
      return cw;
   endfunction

   function automatic logic [DW+EW-2:0] f_from_cw(input logic [NPOS:1] cw);
      logic [DW-1:0] d;
      logic [EW-2:0] c;
      int j;
      int k;
      d = '0;
      c = '0;
      j = 0;
      k = 0;
      for (int pos = 1; pos <= NPOS; pos++) begin
         if ((pos & (pos - 1)) == 0) begin
            c[k] = cw[pos];
            k++;
         end else begin
            d[j] = cw[pos];
            j++;
         end
      end
      return {c, d};
   endfunction

   function automatic logic f_parity(input logic [DW-1:0] d, input logic [EW-1:0] c);
      return ^{d, c};
   endfunction

   // Result is {overall parity, Hamming syndrome}.
   function automatic logic [EW-1:0] f_syndrome(input logic [DW-1:0] d, input logic [EW-1:0] c);
      logic [NPOS:1] cw;
      logic [EW-1:0] s;
      cw = f_to_cw(d, c[EW-2:0]);
      s  = '0;
      for (int pos = 1; pos <= NPOS; pos++) begin
         for (int k = 0; k < P; k++) begin
            if (((pos >> k) & 1) == 1) begin
               s[k] = s[k] ^ cw[pos];
            end else begin
               s[k] = s[k];
            end
         end
      end
      s[EW-1] = f_parity(d, c);
      return s;
   endfunction

   logic [DW+EW-1:0] w_in_word;
   logic [EW-1:0]    w_in_syn;
   logic             w_s1_adv;
   logic             w_s2_adv;
   logic             w_xfer;
   logic             w_err;
   logic [EW-2:0]    w_syn;
   logic             w_par;
   logic             w_single;
   logic             w_double;
   logic [NPOS:1]    w_flip;
   logic [DW-1:0]    w_cor_data;
   logic [EW-2:0]    w_cor_chk;
   logic [EW-1:0]    w_cor_ecc;

   logic             r_s1_v;
   logic [DW-1:0]    r_s1_data;
   logic [EW-1:0]    r_s1_ecc;
   logic [AW-1:0]    r_s1_addr;
   logic [EW-1:0]    r_s1_syn;
   logic             r_s2_v;
   logic [DW-1:0]    r_s2_data;
   logic [EW-1:0]    r_s2_ecc;
   logic [AW-1:0]    r_s2_addr;
   logic [EW-1:0]    r_s2_syn;
   logic             r_s2_single;
   logic             r_s2_double;
   logic [CNT_W-1:0] r_single_cnt;
   logic [CNT_W-1:0] r_double_cnt;
   logic             r_log_valid;
   logic             r_log_double;
   logic [AW-1:0]    r_log_addr;
   logic [EW-1:0]    r_log_syn;

`ifdef RV_ECC_PIPE_INJECT_EN
   assign w_in_word = {in_ecc, in_data} ^ inject_flip;
`else
   assign w_in_word = {in_ecc, in_data};
`endif

   assign w_in_syn = f_syndrome(w_in_word[DW-1:0], w_in_word[DW+EW-1:DW]);
   assign w_s2_adv = ~r_s2_v | out_ready;
   assign w_s1_adv = ~r_s1_v | w_s2_adv;
   assign w_xfer   = r_s2_v & out_ready;
   assign w_err    = r_s2_single | r_s2_double;

   // Classify the S1 word and build the single-bit correction mask.
   always_comb begin
      w_syn    = r_s1_syn[EW-2:0];
      w_par    = r_s1_syn[EW-1];
      w_single = 1'b0;
      w_double = 1'b0;
      if (w_par) begin
         if (int'(w_syn) > NPOS) begin
            w_double = 1'b1;
         end else begin
            w_single = 1'b1;
         end
      end else if (w_syn != '0) begin
         w_double = 1'b1;
      end else begin
         w_double = 1'b0;
      end
      for (int pos = 1; pos <= NPOS; pos++) begin
         w_flip[pos] = w_single & (int'(w_syn) == pos);
      end
      {w_cor_chk, w_cor_data} = f_from_cw(f_to_cw(r_s1_data, r_s1_ecc[EW-2:0]) ^ w_flip);
      w_cor_ecc = {r_s1_ecc[EW-1] ^ (w_single & (w_syn == '0)), w_cor_chk};
   end

   // Stage S1: capture raw word, tag and syndrome.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_s1_v    <= 1'b0;
         r_s1_data <= '0;
         r_s1_ecc  <= '0;
         r_s1_addr <= '0;
         r_s1_syn  <= '0;
      end else if (w_s1_adv) begin
         r_s1_v <= in_valid;
         if (in_valid) begin
            r_s1_data <= w_in_word[DW-1:0];
            r_s1_ecc  <= w_in_word[DW+EW-1:DW];
            r_s1_addr <= in_addr;
            r_s1_syn  <= w_in_syn;
         end
      end
   end

   // Stage S2: corrected word and flags; double errors pass the raw word through.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_s2_v      <= 1'b0;
         r_s2_data   <= '0;
         r_s2_ecc    <= '0;
         r_s2_addr   <= '0;
         r_s2_syn    <= '0;
         r_s2_single <= 1'b0;
         r_s2_double <= 1'b0;
      end else if (w_s2_adv) begin
         r_s2_v <= r_s1_v;
         if (r_s1_v) begin
            r_s2_data   <= w_double ? r_s1_data : w_cor_data;
            r_s2_ecc    <= w_double ? r_s1_ecc  : w_cor_ecc;
            r_s2_addr   <= r_s1_addr;
            r_s2_syn    <= r_s1_syn;
            r_s2_single <= w_single;
            r_s2_double <= w_double;
         end
      end
   end

   // Saturating error counters; clear wins over a same-cycle increment.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_single_cnt <= '0;
         r_double_cnt <= '0;
      end else if (cnt_clear) begin
         r_single_cnt <= '0;
         r_double_cnt <= '0;
      end else begin
         if (w_xfer && r_s2_single && !(&r_single_cnt)) begin
            r_single_cnt <= r_single_cnt + CNT_W'(1);
         end
         if (w_xfer && r_s2_double && !(&r_double_cnt)) begin
            r_double_cnt <= r_double_cnt + CNT_W'(1);
         end
      end
   end

   // First-error log; a clear in the same cycle as an error re-arms and captures it.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_log_valid  <= 1'b0;
         r_log_double <= 1'b0;
         r_log_addr   <= '0;
         r_log_syn    <= '0;
      end else if (w_xfer && w_err && (!r_log_valid || log_clear)) begin
         r_log_valid  <= 1'b1;
         r_log_double <= r_s2_double;
         r_log_addr   <= r_s2_addr;
         r_log_syn    <= r_s2_syn;
      end else if (log_clear) begin
         r_log_valid  <= 1'b0;
         r_log_double <= 1'b0;
         r_log_addr   <= '0;
         r_log_syn    <= '0;
      end
   end

   assign in_ready       = w_s1_adv;
   assign out_valid      = r_s2_v;
   assign out_data       = r_s2_data;
   assign out_ecc        = r_s2_ecc;
   assign out_addr       = r_s2_addr;
   assign out_single_err = r_s2_single;
   assign out_double_err = r_s2_double;
   assign single_cnt     = r_single_cnt;
   assign double_cnt     = r_double_cnt;
   assign log_valid      = r_log_valid;
   assign log_double     = r_log_double;
   assign log_addr       = r_log_addr;
   assign log_syndrome   = r_log_syn;

endmodule

// File: tb/tb_rvecc_pipe.sv
// Directed table-driven bench for rvecc_pipe at DW=32, AW=16, CNT_W=2.
module tb_rvecc_pipe;
   localparam int DW = 32;
   localparam int AW = 16;
   localparam int CNT_W = 2;
   localparam int EW = 7;

   logic             clk = 1'b0;
   logic             rst_l = 1'b0;
   logic             in_valid, in_ready, out_valid, out_ready;
   logic [DW-1:0]    in_data, out_data;
   logic [EW-1:0]    in_ecc, out_ecc, log_syndrome;
   logic [AW-1:0]    in_addr, out_addr, log_addr;
   logic             out_single_err, out_double_err, cnt_clear, log_clear, log_valid, log_double;
   logic [CNT_W-1:0] single_cnt, double_cnt;

   rvecc_pipe #(.DW(DW), .AW(AW), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_l(rst_l), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_ecc(in_ecc), .in_addr(in_addr),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ecc(out_ecc),
      .out_addr(out_addr), .out_single_err(out_single_err), .out_double_err(out_double_err),
      .cnt_clear(cnt_clear), .single_cnt(single_cnt), .double_cnt(double_cnt),
      .log_clear(log_clear), .log_valid(log_valid), .log_double(log_double),
      .log_addr(log_addr), .log_syndrome(log_syndrome)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] d;
      logic [6:0]  e;
      logic [31:0] xd;
      logic [6:0]  xe;
      logic        xs;
      logic        xdb;
      logic [5:0]  xsyn;
   } vec_t;

   vec_t        tbl[12];
   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] g_data;
   logic [6:0]  g_ecc;
   logic [15:0] g_addr;
   logic        g_s, g_d;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   // One word through an empty pipe; fixed two-cycle latency is checked on the way.
   task automatic xfer(input logic [31:0] d, input logic [6:0] e, input logic [15:0] a,
                       input logic ccl, input logic lcl);
      @(negedge clk);
      in_valid = 1'b1; in_data = d; in_ecc = e; in_addr = a;
      @(negedge clk);
      in_valid = 1'b0;
      check("latency_early", out_valid, 64'd0);
      @(negedge clk);
      check("latency_due", out_valid, 64'd1);
      g_data = out_data; g_ecc = out_ecc; g_addr = out_addr;
      g_s = out_single_err; g_d = out_double_err;
      cnt_clear = ccl; log_clear = lcl;
      @(negedge clk);
      cnt_clear = 1'b0; log_clear = 1'b0;
      check("drained", out_valid, 64'd0);
   endtask

   initial begin
      int          m_s, m_d;
      logic        m_lv, m_ldb;
      logic [15:0] m_la, a;
      logic [5:0]  m_lsyn;

      in_valid = 1'b0; in_data = '0; in_ecc = '0; in_addr = '0;
      out_ready = 1'b1; cnt_clear = 1'b0; log_clear = 1'b0;

      tbl[0]  = '{32'h0000_0000, 7'h00, 32'h0000_0000, 7'h00, 1'b0, 1'b0, 6'h00};
      tbl[1]  = '{32'h0000_0001, 7'h00, 32'h0000_0000, 7'h00, 1'b1, 1'b0, 6'h03};
      tbl[2]  = '{32'h0000_0003, 7'h00, 32'h0000_0003, 7'h00, 1'b0, 1'b1, 6'h06};
      tbl[3]  = '{32'h0000_0000, 7'h40, 32'h0000_0000, 7'h00, 1'b1, 1'b0, 6'h00};
      tbl[4]  = '{32'h0000_0000, 7'h01, 32'h0000_0000, 7'h00, 1'b1, 1'b0, 6'h01};
      tbl[5]  = '{32'h0000_0001, 7'h43, 32'h0000_0001, 7'h43, 1'b0, 1'b0, 6'h00};
      tbl[6]  = '{32'h8000_0001, 7'h43, 32'h0000_0001, 7'h43, 1'b1, 1'b0, 6'h26};
      tbl[7]  = '{32'h0000_0000, 7'h7F, 32'h0000_0000, 7'h7F, 1'b0, 1'b1, 6'h3F};
      tbl[8]  = '{32'h0000_0010, 7'h00, 32'h0000_0000, 7'h00, 1'b1, 1'b0, 6'h09};
      tbl[9]  = '{32'h0000_0800, 7'h00, 32'h0000_0000, 7'h00, 1'b1, 1'b0, 6'h11};
      tbl[10] = '{32'h0000_0000, 7'h20, 32'h0000_0000, 7'h00, 1'b1, 1'b0, 6'h20};
      tbl[11] = '{32'h0000_0000, 7'h03, 32'h0000_0000, 7'h03, 1'b0, 1'b1, 6'h03};

      repeat (3) @(negedge clk);
      check("rst_out_valid", out_valid, 64'd0);
      check("rst_out_data", out_data, 64'd0);
      check("rst_single_cnt", single_cnt, 64'd0);
      check("rst_double_cnt", double_cnt, 64'd0);
      check("rst_log_valid", log_valid, 64'd0);
      rst_l = 1'b1;

      m_s = 0; m_d = 0; m_lv = 1'b0; m_ldb = 1'b0; m_la = '0; m_lsyn = '0;
      for (int i = 0; i < 12; i++) begin
         a = 16'h0A00 + 16'(i);
         xfer(tbl[i].d, tbl[i].e, a, 1'b0, 1'b0);
         check("vec_data", g_data, tbl[i].xd);
         check("vec_ecc", g_ecc, tbl[i].xe);
         check("vec_addr", g_addr, a);
         check("vec_single", g_s, tbl[i].xs);
         check("vec_double", g_d, tbl[i].xdb);
         if (tbl[i].xs && m_s < 3) m_s++;
         if (tbl[i].xdb && m_d < 3) m_d++;
         if (!m_lv && (tbl[i].xs || tbl[i].xdb)) begin
            m_lv = 1'b1; m_ldb = tbl[i].xdb; m_la = a; m_lsyn = tbl[i].xsyn;
         end
         check("vec_single_cnt", single_cnt, m_s);
         check("vec_double_cnt", double_cnt, m_d);
         check("vec_log_valid", log_valid, m_lv);
      end
      check("log_addr", log_addr, m_la);
      check("log_double", log_double, m_ldb);
      check("log_syndrome", log_syndrome[5:0], m_lsyn);

      // Clear concurrent with a new error re-captures it.
      xfer(32'h3, 7'h00, 16'hBEEF, 1'b0, 1'b1);
      check("relog_valid", log_valid, 64'd1);
      check("relog_addr", log_addr, 64'hBEEF);
      check("relog_double", log_double, 64'd1);
      check("relog_syn", log_syndrome[5:0], 64'h06);
      check("double_sat", double_cnt, 64'd3);
      xfer(32'h0, 7'h00, 16'h0001, 1'b0, 1'b1);
      check("log_cleared", log_valid, 64'd0);

      // Back-to-back stream with a three-cycle output stall.
      begin : stream_blk
         int          tx, rx, occ;
         logic        prev_stall;
         logic [15:0] prev_addr;
         tx = 0; rx = 0; occ = 0; prev_stall = 1'b0; prev_addr = '0;
         for (int cyc = 0; cyc < 40 && rx < 8; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 4 && cyc <= 6);
            in_valid  = (tx < 8);
            in_data   = tx[0] ? 32'h1 : 32'h0;
            in_ecc    = tx[0] ? 7'h43 : 7'h00;
            in_addr   = 16'h0100 + 16'(tx);
            #1;
            check("stream_in_ready", in_ready, (occ < 2) || out_ready);
            if (prev_stall) begin
               check("stall_valid", out_valid, 64'd1);
               check("stall_addr", out_addr, prev_addr);
            end
            if (out_valid && out_ready) begin
               check("stream_addr", out_addr, 16'h0100 + 16'(rx));
               check("stream_data", out_data, rx[0] ? 64'd1 : 64'd0);
               rx++; occ--;
            end
            if (in_valid && in_ready) begin
               tx++; occ++;
            end
            prev_stall = out_valid && !out_ready;
            prev_addr  = out_addr;
         end
         @(negedge clk);
         in_valid = 1'b0; out_ready = 1'b1;
         check("stream_count", rx, 64'd8);
         repeat (3) begin
            @(negedge clk);
            check("stream_no_dup", out_valid, 64'd0);
         end
      end

      // Saturation at CNT_W=2, then clear on the sixth erroring transfer.
      @(negedge clk); cnt_clear = 1'b1;
      @(negedge clk); cnt_clear = 1'b0;
      check("cnt_cleared", single_cnt, 64'd0);
      for (int i = 0; i < 5; i++) begin
         xfer(32'h1, 7'h00, 16'h0200, 1'b0, 1'b0);
         check("sat_single_cnt", single_cnt, (i < 3) ? i + 1 : 3);
      end
      xfer(32'h1, 7'h00, 16'h0200, 1'b1, 1'b0);
      check("clr_prio_single", single_cnt, 64'd0);
      check("clr_prio_double", double_cnt, 64'd0);

      // Reset with two words in flight.
      xfer(32'h1, 7'h00, 16'h0250, 1'b0, 1'b0);
      check("pre_rst_cnt", single_cnt, 64'd1);
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; in_data = '0; in_ecc = '0; in_addr = 16'h0300;
      @(negedge clk);
      in_addr = 16'h0301;
      @(negedge clk);
      in_valid = 1'b0;
      check("pre_rst_valid", out_valid, 64'd1);
      #2 rst_l = 1'b0;
      #1;
      check("rst_mid_valid", out_valid, 64'd0);
      check("rst_mid_cnt", single_cnt, 64'd0);
      check("rst_mid_log", log_valid, 64'd0);
      @(negedge clk);
      rst_l = 1'b1; out_ready = 1'b1;
      repeat (6) begin
         @(negedge clk);
         check("post_rst_idle", out_valid, 64'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/rvecc_pipe.md
# rvecc_pipe

Pipelined, parametrised-width SECDED check/correct stage with valid/ready flow control, saturating error counters and a first-error capture log. It generalises the 32-bit combinational ECC decoder to any data width and adds two register stages, so it can sit between a wide SRAM read port (DCCM/ICCM, 32 or 64 bit) and its consumer without lengthening the read path. Throughput is one word per cycle.

## Interface
- DW, 32: data width, 8..128.
- AW, 32: width of the address/tag carried alongside each word.
- CNT_W, 16: error counter width, ≥2.
- EW (localparam): P+1, where P is the smallest value with 2^P ≥ DW+P+1. DW=32 gives 7; DW=64 gives 8.
- clk  in  1  clock.
- rst_l  in  1  asynchronous, active-low reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block accepts the word this cycle.
- in_data  in  DW  raw data read from memory.
- in_ecc  in  EW  stored check bits; bit EW-1 is the overall parity.
- in_addr  in  AW  tag carried through unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  DW  corrected data; passed through uncorrected on a double error.
- out_ecc  out  EW  corrected check bits.
- out_addr  out  AW  tag.
- out_single_err  out  1  correctable error in this word.
- out_double_err  out  1  uncorrectable error in this word.
- cnt_clear  in  1  synchronous clear of both counters.
- single_cnt  out  CNT_W  saturating count of single errors.
- double_cnt  out  CNT_W  saturating count of double errors.
- log_clear  in  1  synchronous clear of the error log.
- log_valid  out  1  the log holds a captured error.
- log_double  out  1  the captured error was a double error.
- log_addr  out  AW  tag of the captured error.
- log_syndrome  out  EW  syndrome of the captured error.

## Operation
- Hamming layout: data bits occupy codeword positions 1..DW+P that are not powers of two, in ascending order. Check bit k covers every position with bit k set. The overall parity is the XOR of all data bits and check bits. For DW=32 this is bit-compatible with the existing 32-bit encoder.
- Stage S1 registers the data, ECC and tag, and computes the syndrome s[EW-2:0] and the parity p.
- Stage S2 corrects and classifies:
  - syndrome 0, p=0: clean word.
  - p=1: single error. Flip codeword position s; s=0 means the parity bit itself is in error.
  - syndrome ≠0, p=0: double error. No correction is applied.
  - p=1 with s > DW+P: classified as a double error.
- Flags, counters and log are updated only on an output transfer (out_valid & out_ready), so each word is counted exactly once.
- Counters:
  - Increment by 1 and saturate at all-ones.
  - cnt_clear takes priority over a same-cycle increment; the counter becomes 0 and that event is not counted.
- Log:
  - Captures on the first erroring transfer while log_valid=0. Later errors are ignored until log_clear.
  - log_clear together with an erroring transfer clears the log and then captures the new error, leaving log_valid=1.
- All outputs reset to 0. Reset mid-operation drops all in-flight words.

## Timing
- Handshake:
  - s2_adv = ~s2_v | out_ready.
  - s1_adv = ~s1_v | s2_adv.
  - in_ready = s1_adv.
  - out_valid = s2_v.
- Latency: an accepted word appears on out_valid 2 cycles later when there is no backpressure.
- While out_valid=1 and out_ready=0, every out_* signal holds stable.
- in_ready depends combinationally on out_ready. No other output depends combinationally on an input.
- Counters and log update at the clock edge that completes the transfer and are visible the following cycle.

## Configuration
- RV_ECC_PIPE_INJECT_EN defined:
  - Adds input inject_flip[DW+EW-1:0], with bits {ecc, data}.
  - inject_flip is XORed into the word at S1 capture, only when the word is accepted.
- Macro undefined: the port is absent and the datapath has no XOR.

## Test plan
- DW=32: in_data=0x0, in_ecc=0x00 → after 2 cycles out_data=0x0, no flags, counters unchanged.
- in_data=0x1, in_ecc=0x00 (single error at codeword position 3) → out_data=0x0, out_single_err=1, single_cnt=1, log_syndrome[5:0]=3, log_double=0.
- in_data=0x3, in_ecc=0x00 → out_data=0x3, out_double_err=1, double_cnt=1. When the log was already valid from the previous scenario, it stays unchanged.
- in_data=0x0, in_ecc=0x40 (parity bit only in error) → single error, out_data=0x0, out_ecc=0x00.
- Stream of 8 back-to-back words with out_ready low for 3 cycles mid-stream → no loss or duplication, order preserved, in_ready low while both stages are full.
- CNT_W=2, 5 single errors, then cnt_clear asserted on the 6th erroring transfer → count reads 3 after the 5th, then 0. Assert rst_l low with 2 words in flight → out_valid=0 and nothing is delivered afterwards.
